// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 multiplexer among four requesters.
// A winner is chosen in IDLE by rotating priority after the last grantee.
// The granted lane is forwarded over a valid/ready port for up to MAX_HOLD
// beats. Every release passes through one IDLE cycle before the next grant.
module mux4_rr_arbiter #(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   din,
    input  logic                  dout_ready,
    output logic [3:0]            gnt,
    output logic                  s1,
    output logic                  s2,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic [3:0]            ack
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] lane [4];
    logic              granted;
    logic [1:0]        sel;
    logic              xfer;
    logic              win_valid;
    logic [1:0]        win_idx;
    logic [1:0]        cand;

    // Split the packed input bus into one entry per requester lane.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = din[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Output decode. The mux select follows the registered grant and returns
    // to lane 0 when idle. Reset suppresses any beat still being offered.
    assign granted    = (state_q == GRANT);
    assign sel        = granted ? idx_q : 2'd0;
    assign s1         = sel[0];
    assign s2         = sel[1];
    assign gnt        = granted ? (4'b0001 << idx_q) : 4'b0000;
    assign dout       = lane[sel];
    assign dout_valid = granted & req[idx_q] & ~rst;
    assign xfer       = dout_valid & dout_ready;
    assign ack        = xfer ? (4'b0001 << idx_q) : 4'b0000;

    // Rotating priority: scan from last+1 upward with wrap. The loop runs
    // from the farthest candidate down, so the nearest requester wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    idx_d   = win_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[idx_q]) begin
                    // Requester withdrew; give the channel up without a beat.
                    last_d  = idx_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (xfer) begin
                    if (cnt_q == CNT_LAST) begin
                        // Hold limit reached; force rotation.
                        last_d  = idx_q;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; last resets to 3 so requester 0 has first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios push expected beats into a
// scoreboard queue; a monitor pops one entry per acknowledged beat.
module tb_mux4_rr_arbiter;

    localparam int DW = 4;
    localparam int MH = 4;

    typedef struct {
        logic [3:0]    ack;
        logic [3:0]    gnt;
        logic [1:0]    sel;
        logic [DW-1:0] data;
    } beat_t;

    logic            clk;
    logic            rst;
    logic [3:0]      req;
    logic [4*DW-1:0] din;
    logic            dout_ready;
    logic [3:0]      gnt;
    logic            s1;
    logic            s2;
    logic [DW-1:0]   dout;
    logic            dout_valid;
    logic [3:0]      ack;

    logic [DW-1:0] lanes [4] = '{4'hA, 4'hB, 4'hC, 4'hD};

    beat_t sb_q[$];
    int    checks = 0;
    int    errors = 0;

    // Withdrawal scenario vectors
    logic [3:0] wd_req [7] = '{4'b1000, 4'b1000, 4'b1000, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
    logic [3:0] wd_gnt [7] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    // Mid-burst reset scenario vectors
    logic       mr_rst [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] mr_req [10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0101,
                                4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000};
    logic [3:0] mr_gnt [10] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};

    assign din = {lanes[3], lanes[2], lanes[1], lanes[0]};

    mux4_rr_arbiter #(
        .DATA_W   (DW),
        .MAX_HOLD (MH)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .din        (din),
        .dout_ready (dout_ready),
        .gnt        (gnt),
        .s1         (s1),
        .s2         (s2),
        .dout       (dout),
        .dout_valid (dout_valid),
        .ack        (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_beats(input int idx, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.ack  = 4'b0001 << idx;
            b.gnt  = 4'b0001 << idx;
            b.sel  = 2'(idx);
            b.data = lanes[idx];
            sb_q.push_back(b);
        end
    endtask

    // One clock cycle: inputs change 1 time unit after the edge and hold for
    // the whole cycle; checks run 3 units after the edge.
    task automatic cyc(input logic r, input logic [3:0] rq, input logic rdy);
        @(posedge clk);
        #1;
        rst        = r;
        req        = rq;
        dout_ready = rdy;
        #2;
    endtask

    // Monitor: every acknowledged beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ack !== 4'b0000) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_ack: got ack=%b expected no beat (t=%0t)", ack, $time);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                chk("mon_ack", 32'(ack), 32'(e.ack));
                chk("mon_gnt", 32'(gnt), 32'(e.gnt));
                chk("mon_sel", 32'({s2, s1}), 32'(e.sel));
                chk("mon_dout", 32'(dout), 32'(e.data));
                chk("mon_valid", 32'(dout_valid), 32'd1);
                $display("beat: ack=%b gnt=%b sel=%0d dout=%h", ack, gnt, {s2, s1}, dout);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        req        = 4'hF;
        dout_ready = 1'b1;

        // Reset with all requesters asking
        cyc(1'b1, 4'hF, 1'b1);
        cyc(1'b1, 4'hF, 1'b1);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_sel", 32'({s2, s1}), 32'd0);
        chk("rst_dout", 32'(dout), 32'(lanes[0]));

        // Rotation 0,1,2,3,0 with a dead cycle between grants
        push_beats(0, 4);
        push_beats(1, 4);
        push_beats(2, 4);
        push_beats(3, 4);
        push_beats(0, 4);
        cyc(1'b0, 4'hF, 1'b1);
        chk("rot_first_idle", 32'(gnt), 32'd0);
        for (int k = 0; k < 25; k++) begin
            cyc(1'b0, (k == 24) ? 4'h0 : 4'hF, 1'b1);
            chk("rot_gnt", 32'(gnt), (k % 5 == 4) ? 32'd0 : 32'(4'b0001 << ((k / 5) % 4)));
        end

        // Single requester 2: two full bursts with one idle cycle between
        push_beats(2, 8);
        for (int k = 0; k < 11; k++) begin
            cyc(1'b0, (k == 10) ? 4'h0 : 4'b0100, 1'b1);
            chk("single_gnt", 32'(gnt), (k == 0 || k == 5 || k == 10) ? 32'd0 : 32'h4);
        end

        // Backpressure on requester 1 for 5 cycles
        push_beats(1, 4);
        for (int k = 0; k < 11; k++) begin
            cyc(1'b0, (k == 10) ? 4'h0 : 4'b0010, (k >= 6));
            chk("bp_gnt", 32'(gnt), (k == 0 || k == 10) ? 32'd0 : 32'h2);
            if (k >= 1 && k <= 5) begin
                chk("bp_valid", 32'(dout_valid), 32'd1);
                chk("bp_ack", 32'(ack), 32'd0);
            end
        end

        // Withdrawal by requester 3 after 2 beats; wrap to 0
        push_beats(3, 2);
        for (int k = 0; k < 7; k++) begin
            cyc(1'b0, wd_req[k], 1'b1);
            chk("wd_gnt", 32'(gnt), 32'(wd_gnt[k]));
            if (k == 3 || k == 5) begin
                chk("wd_valid", 32'(dout_valid), 32'd0);
                chk("wd_ack", 32'(ack), 32'd0);
            end
        end

        // Mid-burst reset while requester 1 holds the grant at beat 2
        push_beats(1, 2);
        push_beats(0, 4);
        for (int k = 0; k < 10; k++) begin
            cyc(mr_rst[k], mr_req[k], 1'b1);
            chk("mr_gnt", 32'(gnt), 32'(mr_gnt[k]));
            if (k == 3) begin
                chk("mr_valid", 32'(dout_valid), 32'd0);
                chk("mr_ack", 32'(ack), 32'd0);
            end
        end

        cyc(1'b0, 4'h0, 1'b1);
        cyc(1'b0, 4'h0, 1'b1);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
